// File: rtl/issue_dispatch_queue.sv
// issue_dispatch_queue: in-order dispatch buffer in front of one issue bank.
// Holds renamed uops, keeps their source readiness current with the wakeup bus,
// and writes the oldest uop into the bank whenever the bank has room.
// Optional macro ISSUE_DISPATCH_BYPASS_EN: an empty queue forwards the incoming
// uop straight to the bank in the same cycle instead of enqueuing it.
module issue_dispatch_queue #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned PREG_WIDTH = 7,
    parameter int unsigned WB_SIZE    = 4,
    parameter int unsigned ROB_WIDTH  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PREG_WIDTH-1:0]         in_rs1,
    input  logic [PREG_WIDTH-1:0]         in_rs2,
    input  logic                          in_rs1v,
    input  logic                          in_rs2v,
    input  logic                          in_we,
    input  logic [PREG_WIDTH-1:0]         in_rd,
    input  logic [ROB_WIDTH:0]            in_rob,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [WB_SIZE-1:0]            wb_en,
    input  logic [WB_SIZE-1:0]            wb_we,
    input  logic [WB_SIZE*PREG_WIDTH-1:0] wb_rd,
    input  logic                          redirect,
    input  logic [ROB_WIDTH:0]            redirect_idx,
    input  logic                          bank_full,
    output logic                          bank_en,
    output logic [PREG_WIDTH-1:0]         bank_rs1,
    output logic [PREG_WIDTH-1:0]         bank_rs2,
    output logic                          bank_rs1v,
    output logic                          bank_rs2v,
    output logic [PREG_WIDTH-1:0]         bank_rd,
    output logic                          bank_we,
    output logic [ROB_WIDTH:0]            bank_rob,
    output logic [DATA_WIDTH-1:0]         bank_data
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Entry storage: control bits are reset, payload is not.
    logic [QDEPTH-1:0]     q_valid;
    logic [QDEPTH-1:0]     q_rs1v;
    logic [QDEPTH-1:0]     q_rs2v;
    logic [PREG_WIDTH-1:0] q_rs1  [QDEPTH];
    logic [PREG_WIDTH-1:0] q_rs2  [QDEPTH];
    logic [PREG_WIDTH-1:0] q_rd   [QDEPTH];
    logic                  q_we   [QDEPTH];
    logic [ROB_WIDTH:0]    q_rob  [QDEPTH];
    logic [DATA_WIDTH-1:0] q_data [QDEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             q_pop;
    logic             push;
    logic             enq;
    logic             bypass;
    logic             in_hit1;
    logic             in_hit2;
    logic [QDEPTH-1:0] wake1;
    logic [QDEPTH-1:0] wake2;
    logic [QDEPTH-1:0] keep;
    logic [CNT_W-1:0]  n_keep;

    // Any wakeup port writing preg p this cycle.
    function automatic logic wake_hit(
        input logic [PREG_WIDTH-1:0]         p,
        input logic [WB_SIZE-1:0]            en,
        input logic [WB_SIZE-1:0]            we,
        input logic [WB_SIZE*PREG_WIDTH-1:0] rd
    );
        logic h;
        h = 1'b0;
        for (int unsigned j = 0; j < WB_SIZE; j++) begin
            if (en[j] && we[j] && (rd[j*PREG_WIDTH +: PREG_WIDTH] == p)) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    // True when robIdx e is strictly older than the flush boundary r.
    function automatic logic is_older(
        input logic [ROB_WIDTH:0] e,
        input logic [ROB_WIDTH:0] r
    );
        logic res;
        if (e[ROB_WIDTH] == r[ROB_WIDTH]) begin
            res = (e[ROB_WIDTH-1:0] < r[ROB_WIDTH-1:0]);
        end else begin
            res = (e[ROB_WIDTH-1:0] > r[ROB_WIDTH-1:0]);
        end
        return res;
    endfunction

    // Handshake and pop/push qualification.
    always_comb begin
        in_ready = (count != FULL_CNT) && !redirect;
        q_pop    = (count != '0) && !bank_full && !redirect;
        push     = in_valid && in_ready;
`ifdef ISSUE_DISPATCH_BYPASS_EN
        bypass   = (count == '0) && in_valid && !bank_full && !redirect;
`else
        bypass   = 1'b0;
`endif
        enq      = push && !bypass;
        in_hit1  = wake_hit(in_rs1, wb_en, wb_we, wb_rd);
        in_hit2  = wake_hit(in_rs2, wb_en, wb_we, wb_rd);
    end

    // Per-entry readiness after this cycle's wakeups.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int unsigned e = 0; e < QDEPTH; e++) begin
            wake1[e] = q_rs1v[e] | wake_hit(q_rs1[e], wb_en, wb_we, wb_rd);
            wake2[e] = q_rs2v[e] | wake_hit(q_rs2[e], wb_en, wb_we, wb_rd);
        end
    end

    // Redirect survivors: the queue is in program order, so survivors form a
    // prefix starting at head; the first flushed entry ends the scan.
    always_comb begin
        logic             run;
        logic [PTR_W-1:0] slot;
        keep   = '0;
        n_keep = '0;
        run    = 1'b1;
        slot   = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            slot = head + PTR_W'(i);
            if (run && (CNT_W'(i) < count) && is_older(q_rob[slot], redirect_idx)) begin
                keep[slot] = 1'b1;
                n_keep     = n_keep + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Bank write port: head entry with same-cycle wakeup bypass, or the
    // incoming uop when it bypasses an empty queue.
    always_comb begin
        bank_en   = q_pop;
        bank_rs1  = q_rs1[head];
        bank_rs2  = q_rs2[head];
        bank_rs1v = wake1[head];
        bank_rs2v = wake2[head];
        bank_rd   = q_rd[head];
        bank_we   = q_we[head];
        bank_rob  = q_rob[head];
        bank_data = q_data[head];
        if (bypass) begin
            bank_en   = 1'b1;
            bank_rs1  = in_rs1;
            bank_rs2  = in_rs2;
            bank_rs1v = in_rs1v | in_hit1;
            bank_rs2v = in_rs2v | in_hit2;
            bank_rd   = in_rd;
            bank_we   = in_we;
            bank_rob  = in_rob;
            bank_data = in_data;
        end
    end

    // Pointers, occupancy and readiness bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
            q_rs1v  <= '0;
            q_rs2v  <= '0;
        end else begin
            for (int unsigned e = 0; e < QDEPTH; e++) begin
                if (q_valid[e]) begin
                    q_rs1v[e] <= wake1[e];
                    q_rs2v[e] <= wake2[e];
                end
            end
            if (redirect) begin
                q_valid <= q_valid & keep;
                tail    <= head + n_keep[PTR_W-1:0];
                count   <= n_keep;
            end else begin
                if (enq) begin
                    q_valid[tail] <= 1'b1;
                    q_rs1v[tail]  <= in_rs1v | in_hit1;
                    q_rs2v[tail]  <= in_rs2v | in_hit2;
                    tail          <= tail + PTR_ONE;
                end
                if (q_pop) begin
                    q_valid[head] <= 1'b0;
                    head          <= head + PTR_ONE;
                end
                if (enq && !q_pop) begin
                    count <= count + CNT_W'(1);
                end else if (!enq && q_pop) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Payload capture at the tail on enqueue.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rs1[tail]  <= in_rs1;
            q_rs2[tail]  <= in_rs2;
            q_rd[tail]   <= in_rd;
            q_we[tail]   <= in_we;
            q_rob[tail]  <= in_rob;
            q_data[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Self-checking bench for issue_dispatch_queue: directed scenarios plus random
// traffic, compared against a sequence-numbered queue reference model.
module tb_issue_dispatch_queue;

    localparam int unsigned DW  = 64;
    localparam int unsigned QD  = 4;
    localparam int unsigned PW  = 7;
    localparam int unsigned WB  = 4;
    localparam int unsigned RBW = 6;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_rs1;
    logic [PW-1:0]    in_rs2;
    logic             in_rs1v;
    logic             in_rs2v;
    logic             in_we;
    logic [PW-1:0]    in_rd;
    logic [RBW:0]     in_rob;
    logic [DW-1:0]    in_data;
    logic [WB-1:0]    wb_en;
    logic [WB-1:0]    wb_we;
    logic [WB*PW-1:0] wb_rd;
    logic             redirect;
    logic [RBW:0]     redirect_idx;
    logic             bank_full;
    logic             bank_en;
    logic [PW-1:0]    bank_rs1;
    logic [PW-1:0]    bank_rs2;
    logic             bank_rs1v;
    logic             bank_rs2v;
    logic [PW-1:0]    bank_rd;
    logic             bank_we;
    logic [RBW:0]     bank_rob;
    logic [DW-1:0]    bank_data;

    issue_dispatch_queue #(
        .DATA_WIDTH(DW), .QDEPTH(QD), .PREG_WIDTH(PW), .WB_SIZE(WB), .ROB_WIDTH(RBW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1v(in_rs1v), .in_rs2v(in_rs2v),
        .in_we(in_we), .in_rd(in_rd), .in_rob(in_rob), .in_data(in_data),
        .wb_en(wb_en), .wb_we(wb_we), .wb_rd(wb_rd),
        .redirect(redirect), .redirect_idx(redirect_idx),
        .bank_full(bank_full), .bank_en(bank_en),
        .bank_rs1(bank_rs1), .bank_rs2(bank_rs2),
        .bank_rs1v(bank_rs1v), .bank_rs2v(bank_rs2v),
        .bank_rd(bank_rd), .bank_we(bank_we), .bank_rob(bank_rob), .bank_data(bank_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: uops carry an unbounded program-order sequence number;
    // robIdx is just that number modulo the ROB index space.
    typedef struct {
        int unsigned   seq;
        logic [PW-1:0] rs1;
        logic [PW-1:0] rs2;
        logic [PW-1:0] rd;
        logic          we;
        logic          rs1v;
        logic          rs2v;
        logic [DW-1:0] data;
    } uop_t;

    uop_t        model_q[$];
    int unsigned next_seq;
    int unsigned redir_seq;
    int          n_checks;
    int          n_errors;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [PW-1:0] p);
        logic h;
        h = 1'b0;
        for (int j = 0; j < int'(WB); j++) begin
            if (wb_en[j] && wb_we[j] && (wb_rd[j*PW +: PW] == p)) h = 1'b1;
        end
        return h;
    endfunction

    task automatic idle();
        in_valid     = 1'b0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_rs1v      = 1'b0;
        in_rs2v      = 1'b0;
        in_we        = 1'b0;
        in_rd        = '0;
        in_data      = '0;
        wb_en        = '0;
        wb_we        = '0;
        wb_rd        = '0;
        redirect     = 1'b0;
        redirect_idx = '0;
    endtask

    task automatic set_uop(input logic [PW-1:0] rs1, input logic v1,
                           input logic [PW-1:0] rs2, input logic v2);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs1v  = v1;
        in_rs2   = rs2;
        in_rs2v  = v2;
        in_we    = 1'(($urandom % 2));
        in_rd    = PW'($urandom_range(0, 127));
        in_data  = {$urandom, $urandom};
    endtask

    // One cycle: called right after a falling edge with inputs already set.
    task automatic step();
        logic exp_ready;
        logic exp_en;
        logic byp;
        uop_t h;
        uop_t n;
        in_rob = next_seq[RBW:0];
        #1;
        exp_ready = (model_q.size() != QD) && !redirect;
        byp = 1'b0;
`ifdef ISSUE_DISPATCH_BYPASS_EN
        byp = (model_q.size() == 0) && in_valid && !bank_full && !redirect;
`endif
        exp_en = byp || ((model_q.size() != 0) && !bank_full && !redirect);
        check_val("in_ready", 64'(in_ready), 64'(exp_ready));
        check_val("bank_en", 64'(bank_en), 64'(exp_en));
        n.seq  = next_seq;
        n.rs1  = in_rs1;
        n.rs2  = in_rs2;
        n.rd   = in_rd;
        n.we   = in_we;
        n.rs1v = in_rs1v | hit(in_rs1);
        n.rs2v = in_rs2v | hit(in_rs2);
        n.data = in_data;
        if (exp_en) begin
            h = byp ? n : model_q[0];
            check_val("bank_rob", 64'(bank_rob), 64'(h.seq[RBW:0]));
            check_val("bank_rs1", 64'(bank_rs1), 64'(h.rs1));
            check_val("bank_rs2", 64'(bank_rs2), 64'(h.rs2));
            check_val("bank_rd", 64'(bank_rd), 64'(h.rd));
            check_val("bank_we", 64'(bank_we), 64'(h.we));
            check_val("bank_data", bank_data, h.data);
            check_val("bank_rs1v", 64'(bank_rs1v), 64'(h.rs1v | hit(h.rs1)));
            check_val("bank_rs2v", 64'(bank_rs2v), 64'(h.rs2v | hit(h.rs2)));
        end
        @(posedge clk);
        foreach (model_q[i]) begin
            model_q[i].rs1v = model_q[i].rs1v | hit(model_q[i].rs1);
            model_q[i].rs2v = model_q[i].rs2v | hit(model_q[i].rs2);
        end
        if (redirect) begin
            while (model_q.size() != 0 && model_q[model_q.size()-1].seq >= redir_seq)
                void'(model_q.pop_back());
            next_seq = redir_seq;
        end else begin
            if (exp_en && !byp) void'(model_q.pop_front());
            if (in_valid && exp_ready) begin
                if (!byp) model_q.push_back(n);
                next_seq++;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        check_val("rst_bank_en", 64'(bank_en), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        model_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        next_seq  = 0;
        redir_seq = 0;
        rst       = 1'b0;
        bank_full = 1'b0;
        in_rob    = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("reset_bank_en", 64'(bank_en), 64'd0);
        check_val("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single uop, rs1 busy, rs2 ready.
        next_seq = 3;
        set_uop(7'd5, 1'b0, 7'd6, 1'b1);
        step();
        idle();
        repeat (2) step();

        // Fill while the bank is full, then drain one per cycle.
        bank_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_uop(PW'(10 + i), 1'b1, PW'(20 + i), 1'b0);
            step();
        end
        bank_full = 1'b0;
        idle();
        repeat (5) step();

        // Wakeup on the head's pop cycle, then on the push cycle.
        bank_full = 1'b1;
        set_uop(7'd9, 1'b0, 7'd3, 1'b0);
        step();
        idle();
        bank_full = 1'b0;
        wb_en = 4'b0100;
        wb_we = 4'b0100;
        wb_rd[2*PW +: PW] = 7'd9;
        step();
        bank_full = 1'b1;
        set_uop(7'd9, 1'b0, 7'd3, 1'b0);
        wb_en = 4'b0100;
        wb_we = 4'b0100;
        wb_rd[2*PW +: PW] = 7'd9;
        step();
        idle();
        bank_full = 1'b0;
        repeat (2) step();

        // Redirect across a ROB direction flip: idx 62,63 kept, 0,1 flushed.
        next_seq  = 62;
        bank_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_uop(PW'(i), 1'b1, PW'(i + 1), 1'b1);
            step();
        end
        idle();
        in_valid     = 1'b1;
        redirect     = 1'b1;
        redirect_idx = 7'b1000000;
        redir_seq    = 64;
        step();
        idle();
        bank_full = 1'b0;
        repeat (3) step();

        // Async reset with three uops queued.
        bank_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_uop(PW'(i), 1'b0, PW'(i), 1'b0);
            step();
        end
        idle();
        bank_full = 1'b0;
        reset_mid();
        step();

        // Toggling back-pressure across pointer wrap.
        for (int i = 0; i < 12; i++) begin
            bank_full = 1'(i % 2);
            set_uop(PW'($urandom_range(0, 15)), 1'b0, PW'($urandom_range(0, 15)), 1'b0);
            step();
        end
        idle();
        bank_full = 1'b0;
        repeat (5) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom % 4 != 0)
                set_uop(PW'($urandom_range(0, 15)), 1'(($urandom % 3) == 0),
                        PW'($urandom_range(0, 15)), 1'(($urandom % 3) == 0));
            bank_full = 1'(($urandom % 10) < 3);
            wb_en = WB'($urandom);
            wb_we = WB'($urandom);
            for (int j = 0; j < int'(WB); j++) wb_rd[j*PW +: PW] = PW'($urandom_range(0, 15));
            if (($urandom % 12) == 0) begin
                redirect  = 1'b1;
                redir_seq = (model_q.size() != 0) ?
                            $urandom_range(model_q[0].seq, next_seq) : next_seq;
                redirect_idx = redir_seq[RBW:0];
            end
            if (($urandom % 150) == 0) begin
                idle();
                reset_mid();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
